// File: rtl/score_pkg.sv
// Shared state encodings, BCD constants and match helper for score_keeper_multi.
// Pure declarations, no latency. No flow control here.
package score_pkg;

    localparam logic [1:0] ST_WAIT   = 2'b00;
    localparam logic [1:0] ST_SCORE  = 2'b01;
    localparam logic [1:0] ST_NEXTRN = 2'b10;
    localparam logic [1:0] ST_OVER   = 2'b11;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when the low w bits of s are all ones (w in 1..32).
    function automatic logic is_match(input logic [31:0] s, input int w);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF >> (32 - w);
        return (s & mask) == mask;
    endfunction

endpackage

// File: rtl/score_keeper_multi_bcd_counter.sv
// Multi-digit BCD counter: saturating increment at 9..9, decrement floored at 0..0.
// One-cycle update on inc/dec/clr. No backpressure; inputs are single-cycle strobes.
module bcd_counter
    import score_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    input  logic                      dec,
    output logic [DIGITS*BCD_W-1:0]   value
);

    logic [DIGITS*BCD_W-1:0] inc_val;
    logic [DIGITS*BCD_W-1:0] dec_val;
    logic                    inc_carry;
    logic                    dec_borrow;

    always_comb begin
        inc_val    = value;
        dec_val    = value;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (value[i*BCD_W +: BCD_W] == BCD_MAX) begin
                    inc_val[i*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    inc_val[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] + 4'd1;
                    inc_carry = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (value[i*BCD_W +: BCD_W] == 4'd0) begin
                    dec_val[i*BCD_W +: BCD_W] = BCD_MAX;
                end else begin
                    dec_val[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] - 4'd1;
                    dec_borrow = 1'b0;
                end
            end
        end
    end

    // A carry or borrow out of the top digit means all nines / all zeros: hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !inc_carry) begin
            value <= inc_val;
        end else if (dec && !dec_borrow) begin
            value <= dec_val;
        end
    end

endmodule

// File: rtl/score_keeper_multi.sv
// Multi-player judge/scorer: all-ones hit check, per-player saturating BCD score, round count.
// Score/LEDs/round_cnt update two edges after the load_player sample. busy marks non-WAIT; submissions outside WAIT are dropped.
// SCORE_PENALTY_EN: when defined, a miss decrements the submitting player's score (floored at 0).
module score_keeper_multi
    import score_pkg::*;
#(
    parameter int SUM_W   = 4,
    parameter int PLAYERS = 2,
    parameter int DIGITS  = 2,
    parameter int ROUNDS  = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_player,
    input  logic                          load_rn,
    input  logic [2:0]                    player_id,
    input  logic [SUM_W-1:0]              sum,
    input  logic                          new_game,
    output logic [PLAYERS*DIGITS*4-1:0]   score_bcd,
    output logic                          gled,
    output logic                          rled,
    output logic [7:0]                    round_cnt,
    output logic                          game_over,
    output logic                          busy
);

    localparam logic [3:0] PLAYERS_L = 4'(PLAYERS);
    localparam logic [7:0] ROUNDS_L  = 8'(ROUNDS);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [2:0] pid;
    logic       hit;
    logic       accept;
    logic       bad_state;
    logic       clr_all;
    logic [7:0] round_inc;

    assign hit       = is_match(32'(sum), SUM_W);
    assign accept    = load_player && ({1'b0, player_id} < PLAYERS_L);
    assign round_inc = round_cnt + 8'd1;
    assign clr_all   = new_game || bad_state;
    assign game_over = (state == ST_OVER);
    assign busy      = (state != ST_WAIT);

    always_comb begin
        state_nxt = state;
        bad_state = 1'b0;
        case (state)
            ST_WAIT:   if (accept) state_nxt = ST_SCORE;
            ST_SCORE:  state_nxt = (round_inc == ROUNDS_L) ? ST_OVER : ST_NEXTRN;
            ST_NEXTRN: if (!load_rn) state_nxt = ST_WAIT;
            ST_OVER:   state_nxt = ST_OVER;
            default: begin
                state_nxt = ST_WAIT;
                bad_state = 1'b1;
            end
        endcase
        if (new_game) state_nxt = ST_WAIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_WAIT;
            pid       <= '0;
            gled      <= 1'b0;
            rled      <= 1'b1;
            round_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (clr_all) begin
                gled      <= 1'b0;
                rled      <= 1'b1;
                round_cnt <= '0;
            end else begin
                if (state == ST_WAIT && accept) pid <= player_id;
                if (state == ST_SCORE) begin
                    gled      <= hit;
                    rled      <= !hit;
                    round_cnt <= round_inc;
                end
            end
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic sel;
        assign sel = (state == ST_SCORE) && (pid == 3'(p)) && !new_game;

        bcd_counter #(.DIGITS(DIGITS)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr_all),
            .inc   (sel && hit),
`ifdef SCORE_PENALTY_EN
            .dec   (sel && !hit),
`else
            .dec   (1'b0),
`endif
            .value (score_bcd[p*DIGITS*4 +: DIGITS*4])
        );
    end

endmodule

// File: tb/tb_score_keeper_multi.sv
// Directed bench for score_keeper_multi: a 2-digit instance (a_*) and a 1-digit, 11-round instance (b_*).
module tb_score_keeper_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_lp = 0, a_rn = 0, a_ng = 0;
    logic [2:0]  a_id = 0;
    logic [3:0]  a_sum = 0;
    logic [15:0] a_score;
    logic        a_gled, a_rled, a_go, a_busy;
    logic [7:0]  a_round;

    logic        b_lp = 0, b_rn = 0, b_ng = 0;
    logic [2:0]  b_id = 0;
    logic [3:0]  b_sum = 0;
    logic [7:0]  b_score;
    logic        b_gled, b_rled, b_go, b_busy;
    logic [7:0]  b_round;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    score_keeper_multi #(.SUM_W(4), .PLAYERS(2), .DIGITS(2), .ROUNDS(200)) u_dut_a (
        .clk(clk), .rst(rst), .load_player(a_lp), .load_rn(a_rn), .player_id(a_id),
        .sum(a_sum), .new_game(a_ng), .score_bcd(a_score), .gled(a_gled), .rled(a_rled),
        .round_cnt(a_round), .game_over(a_go), .busy(a_busy)
    );

    score_keeper_multi #(.SUM_W(4), .PLAYERS(2), .DIGITS(1), .ROUNDS(11)) u_dut_b (
        .clk(clk), .rst(rst), .load_player(b_lp), .load_rn(b_rn), .player_id(b_id),
        .sum(b_sum), .new_game(b_ng), .score_bcd(b_score), .gled(b_gled), .rled(b_rled),
        .round_cnt(b_round), .game_over(b_go), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit on_b, input logic lp, input logic rn,
                         input logic [2:0] id, input logic [3:0] s);
        if (on_b) begin
            b_lp = lp; b_rn = rn; b_id = id; b_sum = s;
        end else begin
            a_lp = lp; a_rn = rn; a_id = id; a_sum = s;
        end
    endtask

    // One full round: strobe with load_rn high, hold load_rn through SCORE, then drop it.
    task automatic play(input bit on_b, input logic [2:0] id, input logic [3:0] s);
        @(negedge clk);
        drive(on_b, 1'b1, 1'b1, id, s);
        @(negedge clk);
        drive(on_b, 1'b0, 1'b1, id, s);
        @(negedge clk);
        drive(on_b, 1'b0, 1'b0, id, s);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("a_rst_score", a_score, 16'h0000);
        check("a_rst_gled",  a_gled, 1'b0);
        check("a_rst_rled",  a_rled, 1'b1);
        check("a_rst_busy",  a_busy, 1'b0);
        check("a_rst_round", a_round, 8'd0);
        check("b_rst_go",    b_go, 1'b0);
        check("b_rst_score", b_score, 8'h00);

        // First hit by player 1, with load_rn already high in WAIT.
        @(negedge clk);
        a_lp = 1; a_rn = 1; a_id = 3'd1; a_sum = 4'hF;
        @(negedge clk);
        a_lp = 0;
        check("a_lat_busy",  a_busy, 1'b1);
        check("a_lat_score", a_score, 16'h0000);
        check("a_lat_round", a_round, 8'd0);
        @(negedge clk);
        check("a_hit_score", a_score, 16'h0100);
        check("a_hit_gled",  a_gled, 1'b1);
        check("a_hit_rled",  a_rled, 1'b0);
        check("a_hit_round", a_round, 8'd1);
        check("a_nextrn_busy", a_busy, 1'b1);
        a_rn = 0;
        @(negedge clk);
        check("a_wait_busy", a_busy, 1'b0);
        check("a_wait_score", a_score, 16'h0100);

        for (int i = 0; i < 9; i++) play(1'b0, 3'd0, 4'hF);
        check("a_pre09_score", a_score, 16'h0109);
        check("a_pre09_round", a_round, 8'd10);

        play(1'b0, 3'd0, 4'hE);
`ifdef SCORE_PENALTY_EN
        check("a_miss_score", a_score, 16'h0108);
`else
        check("a_miss_score", a_score, 16'h0109);
`endif
        check("a_miss_rled", a_rled, 1'b1);
        check("a_miss_gled", a_gled, 1'b0);

        play(1'b0, 3'd0, 4'hF);
`ifdef SCORE_PENALTY_EN
        check("a_carry_score", a_score, 16'h0109);
`else
        check("a_carry_score", a_score, 16'h0110);
`endif
        check("a_carry_round", a_round, 8'd12);

        // Out-of-range player id is dropped.
        @(negedge clk);
        a_lp = 1; a_id = 3'd5; a_sum = 4'hF;
        @(negedge clk);
        a_lp = 0;
        check("a_badid_busy", a_busy, 1'b0);
        @(negedge clk);
        check("a_badid_busy2", a_busy, 1'b0);
        check("a_badid_round", a_round, 8'd12);

        // Asynchronous reset while in SCORE.
        @(negedge clk);
        a_lp = 1; a_rn = 1; a_id = 3'd1; a_sum = 4'hF;
        @(negedge clk);
        a_lp = 0;
        check("a_midscore_busy", a_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("a_arst_score", a_score, 16'h0000);
        check("a_arst_round", a_round, 8'd0);
        check("a_arst_busy",  a_busy, 1'b0);
        check("a_arst_rled",  a_rled, 1'b1);
        @(negedge clk);
        rst = 1'b0; a_rn = 0;
        @(negedge clk);
        check("a_arst_hold_score", a_score, 16'h0000);
        check("a_arst_hold_round", a_round, 8'd0);

        // Two-digit saturation.
        for (int i = 0; i < 99; i++) play(1'b0, 3'd0, 4'hF);
        check("a_99_score", a_score, 16'h0099);
        play(1'b0, 3'd0, 4'hF);
        check("a_sat_score", a_score, 16'h0099);
        check("a_sat_gled",  a_gled, 1'b1);
        check("a_sat_round", a_round, 8'd100);
        play(1'b0, 3'd1, 4'h7);
        check("a_floor_score", a_score, 16'h0099);
        play(1'b0, 3'd0, 4'h0);
`ifdef SCORE_PENALTY_EN
        check("a_dec99_score", a_score, 16'h0098);
`else
        check("a_dec99_score", a_score, 16'h0099);
`endif
        check("a_go_low", a_go, 1'b0);
        check("a_round_102", a_round, 8'd102);

        // Instance B: one digit per player, game ends after 11 rounds.
        play(1'b1, 3'd1, 4'hF);
        check("b_p1_score", b_score, 8'h10);
        for (int i = 0; i < 9; i++) play(1'b1, 3'd0, 4'hF);
        check("b_nine_score", b_score, 8'h19);
        check("b_nine_round", b_round, 8'd10);
        check("b_nine_go",    b_go, 1'b0);
        play(1'b1, 3'd0, 4'hF);
        check("b_sat_score", b_score, 8'h19);
        check("b_over_go",   b_go, 1'b1);
        check("b_over_busy", b_busy, 1'b1);
        check("b_over_round", b_round, 8'd11);
        play(1'b1, 3'd0, 4'hF);
        check("b_ign_score", b_score, 8'h19);
        check("b_ign_round", b_round, 8'd11);
        check("b_ign_go",    b_go, 1'b1);

        @(negedge clk);
        b_ng = 1;
        @(negedge clk);
        b_ng = 0;
        check("b_ng_score", b_score, 8'h00);
        check("b_ng_round", b_round, 8'd0);
        check("b_ng_go",    b_go, 1'b0);
        check("b_ng_busy",  b_busy, 1'b0);
        check("b_ng_rled",  b_rled, 1'b1);
        check("b_ng_gled",  b_gled, 1'b0);

        for (int i = 0; i < 5; i++) play(1'b1, 3'd0, 4'hF);
        check("b_five_score", b_score, 8'h05);
        play(1'b1, 3'd0, 4'h3);
`ifdef SCORE_PENALTY_EN
        check("b_miss5_score", b_score, 8'h04);
`else
        check("b_miss5_score", b_score, 8'h05);
`endif
        play(1'b1, 3'd1, 4'h3);
`ifdef SCORE_PENALTY_EN
        check("b_miss0_score", b_score, 8'h04);
`else
        check("b_miss0_score", b_score, 8'h05);
`endif
        check("b_miss0_round", b_round, 8'd7);

        // new_game beats a simultaneous submission.
        @(negedge clk);
        b_lp = 1; b_id = 3'd0; b_sum = 4'hF; b_ng = 1;
        @(negedge clk);
        b_lp = 0; b_ng = 0;
        check("b_prio_busy",  b_busy, 1'b0);
        check("b_prio_score", b_score, 8'h00);
        check("b_prio_round", b_round, 8'd0);
        @(negedge clk);
        check("b_prio_busy2", b_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
